// File: rtl/alarm_fsm.sv
// Vehicle alarm controller: door/ignition driven Moore FSM with a one-second prescaler and countdown.
// Optional ARMED-state LED blink is built when ALARM_FSM_STATUS_BLINK_EN is defined.
module alarm_fsm #(
    parameter int unsigned CLK_HZ      = 27000000,
    parameter int unsigned T_ARM       = 6,
    parameter int unsigned T_DRIVER    = 8,
    parameter int unsigned T_PASSENGER = 15,
    parameter int unsigned T_ALARM     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ignition,
    input  logic       driver_door,
    input  logic       passenger_door,
    output logic       siren_on,
    output logic       status_led,
    output logic [2:0] state,
    output logic [3:0] seconds_left
);
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [2:0] {
        ST_DISARMED       = 3'd0,
        ST_WAIT_CLOSE     = 3'd1,
        ST_ARM_DELAY      = 3'd2,
        ST_ARMED          = 3'd3,
        ST_TRIGGERED      = 3'd4,
        ST_SOUND_ALARM    = 3'd5,
        ST_WAIT_ALARM_END = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    secs_q, secs_d, secs_load;
    logic          siren_q, siren_d;
    logic          led_q, led_d;
    logic          tick, expire, changed, any_door;

    assign tick     = (presc_q == PW'(CLK_HZ - 1));
    assign expire   = tick && (secs_q == 4'd1);
    assign any_door = driver_door || passenger_door;

    always_comb begin
        state_d   = state_q;
        secs_load = 4'd0;
        case (state_q)
            ST_DISARMED:
                if (!ignition && driver_door) state_d = ST_WAIT_CLOSE;
            ST_WAIT_CLOSE:
                if (!any_door) begin
                    state_d   = ST_ARM_DELAY;
                    secs_load = 4'(T_ARM);
                end
            ST_ARM_DELAY:
                if (any_door)    state_d = ST_WAIT_CLOSE;
                else if (expire) state_d = ST_ARMED;
            ST_ARMED:
                // Driver delay takes precedence when both doors open together.
                if (driver_door) begin
                    state_d   = ST_TRIGGERED;
                    secs_load = 4'(T_DRIVER);
                end else if (passenger_door) begin
                    state_d   = ST_TRIGGERED;
                    secs_load = 4'(T_PASSENGER);
                end
            ST_TRIGGERED:
                if (expire) state_d = ST_SOUND_ALARM;
            ST_SOUND_ALARM:
                if (!any_door) begin
                    state_d   = ST_WAIT_ALARM_END;
                    secs_load = 4'(T_ALARM);
                end
            ST_WAIT_ALARM_END:
                if (any_door)    state_d = ST_SOUND_ALARM;
                else if (expire) state_d = ST_ARMED;
            default:
                state_d = ST_ARMED;
        endcase
        if (ignition && (state_q != ST_DISARMED)) begin
            state_d   = ST_DISARMED;
            secs_load = 4'd0;
        end
    end

    // A state change always restarts the one-second prescaler, even on a tick cycle.
    always_comb begin
        changed = (state_d != state_q);
        presc_d = (changed || tick) ? '0 : presc_q + 1'b1;
        if (changed)
            secs_d = secs_load;
        else if (tick && (secs_q != 4'd0))
            secs_d = secs_q - 4'd1;
        else
            secs_d = secs_q;
    end

    always_comb begin
        siren_d = (state_d == ST_SOUND_ALARM) || (state_d == ST_WAIT_ALARM_END);
        led_d   = 1'b0;
        case (state_d)
            ST_TRIGGERED, ST_SOUND_ALARM, ST_WAIT_ALARM_END:
                led_d = 1'b1;
            ST_ARMED: begin
`ifdef ALARM_FSM_STATUS_BLINK_EN
                if (changed)   led_d = 1'b0;
                else if (tick) led_d = ~led_q;
                else           led_d = led_q;
`else
                led_d = 1'b1;
`endif
            end
            default:
                led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARMED;
            presc_q <= '0;
            secs_q  <= 4'd0;
            siren_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            secs_q  <= secs_d;
            siren_q <= siren_d;
            led_q   <= led_d;
        end
    end

    assign state        = state_q;
    assign seconds_left = secs_q;
    assign siren_on     = siren_q;
    assign status_led   = led_q;
endmodule
